// File: rtl/vidstream_tx.sv
// Raster pixel-stream transmitter: walks a frame store row-major and emits VIDOUT,
// blanking and active-low syncs alongside a divided, registered pixel clock MCKF.
module vidstream_tx #(
  parameter int CLK_DIV      = 14,
  parameter int H_ACTIVE     = 336,
  parameter int H_TOTAL      = 456,
  parameter int V_ACTIVE     = 240,
  parameter int V_TOTAL      = 262,
  parameter int H_SYNC_START = 352,
  parameter int H_SYNC_LEN   = 32,
  parameter int V_SYNC_START = 245,
  parameter int V_SYNC_LEN   = 3
) (
  input  logic        CLOCK_100,
  input  logic        reset,
  input  logic        enable,
  output logic        fb_rd,
  output logic [16:0] fb_addr,
  input  logic [15:0] fb_data,
  output logic [15:0] VIDOUT,
  output logic        MCKF,
  output logic        VIDBLANK_b,
  output logic        HSYNC_b,
  output logic        VSYNC_b,
  output logic        frame_start,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0]  DIV_HALF  = 8'(CLK_DIV / 2);
  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0]  HS_LO     = 10'(H_SYNC_START);
  localparam logic [9:0]  HS_HI     = 10'(H_SYNC_START + H_SYNC_LEN);
  localparam logic [9:0]  VS_LO     = 10'(V_SYNC_START);
  localparam logic [9:0]  VS_HI     = 10'(V_SYNC_START + V_SYNC_LEN);
  localparam logic [16:0] ADDR_LAST = 17'(H_ACTIVE * V_ACTIVE - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [16:0] addr_cnt_q, addr_cnt_d;
  logic [15:0] pix_buf_q, pix_buf_d;
  logic        fb_rd_q, fb_rd_d;
  logic [16:0] fb_addr_q, fb_addr_d;
  logic [15:0] vidout_q, vidout_d;
  logic        mckf_q, mckf_d;
  logic        blank_b_q, blank_b_d;
  logic        hsync_b_q, hsync_b_d;
  logic        vsync_b_q, vsync_b_d;
  logic        frame_start_q, frame_start_d;
  logic        running, active, fetch, present;

  always_comb begin
    state_d       = state_q;
    div_cnt_d     = div_cnt_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    addr_cnt_d    = addr_cnt_q;
    pix_buf_d     = pix_buf_q;
    fb_rd_d       = 1'b0;
    fb_addr_d     = fb_addr_q;
    vidout_d      = vidout_q;
    blank_b_d     = blank_b_q;
    hsync_b_d     = hsync_b_q;
    vsync_b_d     = vsync_b_q;
    frame_start_d = 1'b0;

    case (state_q)
      S_IDLE: if (enable) state_d = S_PRIME;
      S_PRIME, S_RUN: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (div_cnt_q == DIV_LAST) begin
          state_d   = S_RUN;
          div_cnt_d = 8'd0;
          if (h_cnt_q == H_LAST) begin
            h_cnt_d = 10'd0;
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
          end else begin
            h_cnt_d = h_cnt_q + 10'd1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    running = (state_d != S_IDLE);
    if (!running) begin
      div_cnt_d  = 8'd0;
      h_cnt_d    = 10'd0;
      v_cnt_d    = 10'd0;
      addr_cnt_d = 17'd0;
    end

    // Outputs are registered from the next-cycle counters, so each phase
    // event is visible on the cycle whose div_cnt equals that phase.
    active  = (h_cnt_d < H_ACT) && (v_cnt_d < V_ACT);
    fetch   = running && (div_cnt_d == 8'd1) && active;
    present = running && (div_cnt_d == DIV_HALF);

    if (fetch) begin
      fb_rd_d    = 1'b1;
      fb_addr_d  = addr_cnt_q;
      addr_cnt_d = (addr_cnt_q == ADDR_LAST) ? 17'd0 : addr_cnt_q + 17'd1;
    end

    // fb_data is valid on the cycle after the fb_rd cycle, i.e. at phase 2.
    if (state_q != S_IDLE && div_cnt_q == 8'd2) pix_buf_d = fb_data;

    if (present) begin
      vidout_d      = active ? pix_buf_q : 16'd0;
      blank_b_d     = active;
      hsync_b_d     = !((h_cnt_d >= HS_LO) && (h_cnt_d < HS_HI));
      vsync_b_d     = !((v_cnt_d >= VS_LO) && (v_cnt_d < VS_HI));
      frame_start_d = (h_cnt_d == 10'd0) && (v_cnt_d == 10'd0);
    end

    mckf_d = (state_d == S_RUN) && (div_cnt_d < DIV_HALF);

    if (!running) begin
      fb_addr_d = 17'd0;
      vidout_d  = 16'd0;
      blank_b_d = 1'b0;
      hsync_b_d = 1'b1;
      vsync_b_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_100) begin
    if (reset) begin
      state_q       <= S_IDLE;
      div_cnt_q     <= 8'd0;
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      addr_cnt_q    <= 17'd0;
      pix_buf_q     <= 16'd0;
      fb_rd_q       <= 1'b0;
      fb_addr_q     <= 17'd0;
      vidout_q      <= 16'd0;
      mckf_q        <= 1'b0;
      blank_b_q     <= 1'b0;
      hsync_b_q     <= 1'b1;
      vsync_b_q     <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      addr_cnt_q    <= addr_cnt_d;
      pix_buf_q     <= pix_buf_d;
      fb_rd_q       <= fb_rd_d;
      fb_addr_q     <= fb_addr_d;
      vidout_q      <= vidout_d;
      mckf_q        <= mckf_d;
      blank_b_q     <= blank_b_d;
      hsync_b_q     <= hsync_b_d;
      vsync_b_q     <= vsync_b_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign fb_rd       = fb_rd_q;
  assign fb_addr     = fb_addr_q;
  assign VIDOUT      = vidout_q;
  assign MCKF        = mckf_q;
  assign VIDBLANK_b  = blank_b_q;
  assign HSYNC_b     = hsync_b_q;
  assign VSYNC_b     = vsync_b_q;
  assign frame_start = frame_start_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_vidstream_tx.sv
// Bench for vidstream_tx: a full-size instance and a small-geometry instance,
// each fed by a one-cycle-latency frame store returning its own address.
module tb_vidstream_tx;

  typedef struct packed {
    logic        rd;
    logic [16:0] addr;
    logic [15:0] vid;
    logic        mckf;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        fs;
  } out_t;

  typedef struct {
    int          t;
    logic        rd;
    logic [16:0] addr;
    logic [15:0] vid;
    logic        mckf;
    logic        blank;
    logic        hs;
    logic        fs;
  } vec_t;

  localparam out_t RST = '{rd: 1'b0, addr: 17'd0, vid: 16'd0, mckf: 1'b0,
                           blank: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};
  localparam int T_DROP = (5 * 456 + 100) * 14 + 3;

  logic clk, rst, en;
  logic        rd_a, mckf_a, blank_a, hs_a, vs_a, fs_a;
  logic [16:0] addr_a;
  logic [15:0] data_a, vid_a;
  logic [1:0]  dbg_a;
  logic        rd_b, mckf_b, blank_b, hs_b, vs_b, fs_b;
  logic [16:0] addr_b;
  logic [15:0] data_b, vid_b;
  logic [1:0]  dbg_b;

  int checks = 0;
  int failures = 0;
  int cur_t = 0;
  bit sb_on = 1'b0;
  logic [16:0] exp_q[$];
  vec_t tbl[$];
  int fs_t[$];

  vidstream_tx dut_a (
    .CLOCK_100(clk), .reset(rst), .enable(en),
    .fb_rd(rd_a), .fb_addr(addr_a), .fb_data(data_a),
    .VIDOUT(vid_a), .MCKF(mckf_a), .VIDBLANK_b(blank_a),
    .HSYNC_b(hs_a), .VSYNC_b(vs_a), .frame_start(fs_a), .dbg_state(dbg_a)
  );

  vidstream_tx #(
    .CLK_DIV(8), .H_ACTIVE(5), .H_TOTAL(9), .V_ACTIVE(3), .V_TOTAL(6),
    .H_SYNC_START(6), .H_SYNC_LEN(2), .V_SYNC_START(4), .V_SYNC_LEN(1)
  ) dut_b (
    .CLOCK_100(clk), .reset(rst), .enable(en),
    .fb_rd(rd_b), .fb_addr(addr_b), .fb_data(data_b),
    .VIDOUT(vid_b), .MCKF(mckf_b), .VIDBLANK_b(blank_b),
    .HSYNC_b(hs_b), .VSYNC_b(vs_b), .frame_start(fs_b), .dbg_state(dbg_b)
  );

  // clock / frame-store models
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    data_a <= rd_a ? addr_a[15:0] : 16'hDEAD;
    data_b <= rd_b ? addr_b[15:0] : 16'hDEAD;
  end

  // fetch-order scoreboard on the small instance
  always @(posedge clk) begin
    if (sb_on && rd_b && exp_q.size() > 0) begin
      logic [16:0] e;
      e = exp_q.pop_front();
      checks++;
      if (addr_b !== e) begin
        failures++;
        $display("FAIL fetch_order_b t=%0d actual=%0d required=%0d", cur_t, addr_b, e);
      end
    end
  end

  function automatic out_t get_a();
    return '{rd: rd_a, addr: addr_a, vid: vid_a, mckf: mckf_a, blank: blank_a,
             hs: hs_a, vs: vs_a, fs: fs_a};
  endfunction

  function automatic out_t get_b();
    return '{rd: rd_b, addr: addr_b, vid: vid_b, mckf: mckf_b, blank: blank_b,
             hs: hs_b, vs: vs_b, fs: fs_b};
  endfunction

  // Closed-form expectation from cycles elapsed since PRIME entry.
  function automatic out_t model(int t, int cd, int ha, int ht, int va, int vt,
                                 int hss, int hsl, int vss, int vsl);
    out_t o;
    int p, ph, q, h, v;
    o = RST;
    p = t / cd;
    ph = t % cd;
    h = p % ht;
    v = (p / ht) % vt;
    if (ph == 1 && h < ha && v < va) begin
      o.rd = 1'b1;
      o.addr = 17'(v * ha + h);
    end
    q = (ph >= cd / 2) ? p : p - 1;
    if (q >= 0) begin
      h = q % ht;
      v = (q / ht) % vt;
      o.blank = (h < ha) && (v < va);
      o.vid = o.blank ? 16'(v * ha + h) : 16'd0;
      o.hs = !(h >= hss && h < hss + hsl);
      o.vs = !(v >= vss && v < vss + vsl);
      o.fs = (ph == cd / 2) && (h == 0) && (v == 0);
    end
    o.mckf = (t >= cd) && (ph < cd / 2);
    return o;
  endfunction

  task automatic check_out(input string name, input out_t act, input out_t exp,
                           input bit full_addr);
    bit ok;
    ok = (act.rd === exp.rd) && (act.vid === exp.vid) && (act.mckf === exp.mckf) &&
         (act.blank === exp.blank) && (act.hs === exp.hs) && (act.vs === exp.vs) &&
         (act.fs === exp.fs) && ((!full_addr && !exp.rd) || act.addr === exp.addr);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s t=%0d actual rd=%b addr=%0d vid=%h mckf=%b blank=%b hs=%b vs=%b fs=%b required rd=%b addr=%0d vid=%h mckf=%b blank=%b hs=%b vs=%b fs=%b",
               name, cur_t, act.rd, act.addr, act.vid, act.mckf, act.blank, act.hs, act.vs, act.fs,
               exp.rd, exp.addr, exp.vid, exp.mckf, exp.blank, exp.hs, exp.vs, exp.fs);
    end
  endtask

  task automatic check_models(input int t);
    cur_t = t;
    check_out("run_a", get_a(), model(t, 14, 336, 456, 240, 262, 352, 32, 245, 3), 1'b0);
    check_out("run_b", get_b(), model(t, 8, 5, 9, 3, 6, 6, 2, 4, 1), 1'b0);
  endtask

  task automatic check_reset(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      cur_t = i;
      check_out({name, "_a"}, get_a(), RST, 1'b1);
      check_out({name, "_b"}, get_b(), RST, 1'b1);
      @(posedge clk); #1;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic add_vec(input int t, input bit rd, input int addr, input int vid,
                         input bit mckf, input bit blank, input bit hs, input bit fs);
    vec_t v;
    v.t = t; v.rd = rd; v.addr = 17'(addr); v.vid = 16'(vid);
    v.mckf = mckf; v.blank = blank; v.hs = hs; v.fs = fs;
    tbl.push_back(v);
  endtask

  initial begin
    int ti;
    out_t e;

    //       t     rd addr vid  mckf blank hs fs
    add_vec(0,     0, 0,   0,   0,   0,    1, 0);
    add_vec(1,     1, 0,   0,   0,   0,    1, 0);
    add_vec(7,     0, 0,   0,   0,   1,    1, 1);
    add_vec(13,    0, 0,   0,   0,   1,    1, 0);
    add_vec(14,    0, 0,   0,   1,   1,    1, 0);
    add_vec(15,    1, 1,   0,   1,   1,    1, 0);
    add_vec(21,    0, 0,   1,   0,   1,    1, 0);
    add_vec(4697,  0, 0,   335, 0,   1,    1, 0);
    add_vec(4711,  0, 0,   0,   0,   0,    1, 0);
    add_vec(4934,  0, 0,   0,   1,   0,    1, 0);
    add_vec(4935,  0, 0,   0,   0,   0,    0, 0);
    add_vec(5382,  0, 0,   0,   1,   0,    0, 0);
    add_vec(5383,  0, 0,   0,   0,   0,    1, 0);
    add_vec(6384,  0, 0,   0,   1,   0,    1, 0);
    add_vec(6385,  1, 336, 0,   1,   0,    1, 0);
    add_vec(6391,  0, 0,   336, 0,   1,    1, 0);

    for (int f = 0; f < 4; f++)
      for (int a = 0; a < 15; a++) exp_q.push_back(17'(a));

    rst = 1'b1;
    en = 1'b0;
    repeat (3) step();
    check_reset("in_reset", 2);
    @(negedge clk) rst = 1'b0;
    step();
    check_reset("idle", 100);

    // main run: line 0/1 vectors, then up to pixel (100,5)
    @(negedge clk) en = 1'b1;
    sb_on = 1'b1;
    step();
    ti = 0;
    for (int t = 0; t <= T_DROP; t++) begin
      check_models(t);
      if (ti < tbl.size() && tbl[ti].t == t) begin
        e = RST;
        e.rd = tbl[ti].rd; e.addr = tbl[ti].addr; e.vid = tbl[ti].vid;
        e.mckf = tbl[ti].mckf; e.blank = tbl[ti].blank; e.hs = tbl[ti].hs;
        e.fs = tbl[ti].fs;
        check_out("vec_a", get_a(), e, tbl[ti].rd);
        ti++;
      end
      if (fs_b) fs_t.push_back(t);
      if (t != T_DROP) step();
    end
    sb_on = 1'b0;

    checks++;
    if (ti != tbl.size()) begin
      failures++;
      $display("FAIL vec_count actual=%0d required=%0d", ti, tbl.size());
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL fetch_order_left actual=%0d required=0", exp_q.size());
    end
    checks++;
    if (fs_t.size() < 2 || fs_t[0] != 4 || fs_t[1] - fs_t[0] != 9 * 6 * 8) begin
      failures++;
      $display("FAIL frame_period_b actual_first=%0d actual_count=%0d required_first=4 required_period=%0d",
               (fs_t.size() > 0) ? fs_t[0] : -1, fs_t.size(), 9 * 6 * 8);
    end

    // enable drop mid-line
    @(negedge clk) en = 1'b0;
    step();
    check_reset("drop", 6);

    // re-enable, then reset mid-line with enable held
    @(negedge clk) en = 1'b1;
    step();
    for (int t = 0; t <= 200 * 14 + 3; t++) begin
      check_models(t);
      if (t != 200 * 14 + 3) step();
    end
    @(negedge clk) rst = 1'b1;
    step();
    check_reset("mid_reset", 3);
    @(negedge clk) rst = 1'b0;
    step();
    for (int t = 0; t <= 200; t++) begin
      check_models(t);
      if (t != 200) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vidstream_tx.md
# vidstream_tx

Pixel-stream transmitter that turns a 336×240 16-bit frame store into the raster pixel stream the display side consumes: `VIDOUT` with `MCKF` pixel clock, `VIDBLANK_b`, and active-low syncs. It sits between the frame store's read port and the display output block. It runs entirely on `CLOCK_100` and derives `MCKF` as a divided, registered clock. Data and blanking change on `MCKF` falling edges, so the receiver samples them on rising edges.

## Interface
- `CLK_DIV`, 14: `CLOCK_100` cycles per pixel; must be even and ≥ 8.
- `H_ACTIVE`, 336: active pixels per line.
- `H_TOTAL`, 456: pixel periods per line.
- `V_ACTIVE`, 240: active lines per frame.
- `V_TOTAL`, 262: lines per frame.
- `H_SYNC_START`, 352; `H_SYNC_LEN`, 32: `HSYNC_b` low window, in pixels.
- `V_SYNC_START`, 245; `V_SYNC_LEN`, 3: `VSYNC_b` low window, in lines.

Ports:
- `CLOCK_100`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  run request.
- `fb_rd`  out  1  frame-store read strobe.
- `fb_addr`  out  17  linear pixel address, row-major (0..80639).
- `fb_data`  in  16  read data, valid exactly 1 cycle after `fb_rd`.
- `VIDOUT`  out  16  pixel data; [11:8]=R, [7:4]=G, [3:0]=B, [15:12] passed through.
- `MCKF`  out  1  pixel clock.
- `VIDBLANK_b`  out  1  1 = active pixel.
- `HSYNC_b`, `VSYNC_b`  out  1 each  active-low syncs.
- `frame_start`  out  1  one-cycle pulse when pixel (0,0) is presented.

## Operation
- FSM states: IDLE, PRIME, RUN.
  - IDLE → PRIME when `enable`=1.
  - PRIME → RUN when `div_cnt`=CLK_DIV-1.
  - PRIME or RUN → IDLE on the first cycle `enable`=0, taking effect immediately, including mid-line.
- IDLE:
  - `div_cnt`=0, `h_cnt`=0, `v_cnt`=0, `addr_cnt`=0.
  - All outputs held at reset values.
- `div_cnt` counts 0..CLK_DIV-1 and wraps in PRIME and RUN.
- `h_cnt`/`v_cnt` give the pixel being prepared.
  - Both advance when `div_cnt`=CLK_DIV-1.
  - `h_cnt` wraps at H_TOTAL-1 and increments `v_cnt`.
  - `v_cnt` wraps at V_TOTAL-1 back to 0.
- Active region: `h_cnt` < H_ACTIVE && `v_cnt` < V_ACTIVE.
- Fetch, at `div_cnt`=1 when active:
  - `fb_rd`=1 for one cycle, with `fb_addr`=`addr_cnt`.
  - `addr_cnt` increments after the fetch.
  - `addr_cnt` resets to 0 after address 80639, at the frame wrap.
  - No `fb_rd` outside the active region.
- Capture: `fb_data` is registered into `pix_buf` at `div_cnt`=2.
- Present, at `div_cnt`=CLK_DIV/2:
  - `VIDOUT` ← active ? `pix_buf` : 0.
  - `VIDBLANK_b` ← active.
  - `HSYNC_b` ← !(H_SYNC_START ≤ `h_cnt` < H_SYNC_START+H_SYNC_LEN).
  - `VSYNC_b` ← !(V_SYNC_START ≤ `v_cnt` < V_SYNC_START+V_SYNC_LEN).
  - `frame_start` pulses for this one cycle iff `h_cnt`=0 and `v_cnt`=0.
- `MCKF`:
  - Registered; high while `div_cnt` ∈ [0, CLK_DIV/2-1], low otherwise.
  - Forced low throughout PRIME, so PRIME produces no rising edge.
- Address width: `addr_cnt` is 17 bits, with no multiply; it is incremented only on active fetches.

## Timing
- Reset values: `VIDOUT`=0, `MCKF`=0, `VIDBLANK_b`=0, `HSYNC_b`=1, `VSYNC_b`=1, `fb_rd`=0, `fb_addr`=0, `frame_start`=0. State is IDLE.
- Reset has priority over `enable`. Reset mid-frame returns to IDLE on the next edge.
- PRIME is one pixel period (CLK_DIV cycles). It fetches and presents pixel (0,0), then `h_cnt` advances.
- First `MCKF` rising edge: the first RUN cycle, CLK_DIV cycles after PRIME entry. Pixel (0,0) is stable on `VIDOUT` at that edge.
- Pipeline per pixel: fetch at phase 1, capture at phase 2, present at phase CLK_DIV/2. The receiver samples at the next phase 0.
  - Data are therefore stable CLK_DIV/2 cycles before and after each rising edge.
- Pixel period = CLK_DIV cycles. Line = H_TOTAL×CLK_DIV cycles. Frame = V_TOTAL lines.
- `enable` drop: next cycle is IDLE, with reset output values. Re-enable restarts at (0,0) with a new PRIME.

## Test plan
- Reset then hold `enable`=0 for 100 cycles → all outputs at reset values; no `fb_rd`, no `MCKF` edge.
- Assert `enable`; memory model returns `fb_data`=`fb_addr` → `fb_rd`@addr 0 at cycle 1 of PRIME; first `MCKF` rise 14 cycles after PRIME entry with `VIDOUT`=0x0000 and `VIDBLANK_b`=1; `frame_start` pulse 7 cycles after PRIME entry.
- Run to end of line 0 → `VIDOUT`=335 on pixel 335; then 120 pixels with `VIDOUT`=0, `VIDBLANK_b`=0, no `fb_rd`; `HSYNC_b` low for exactly 32×14 cycles starting at pixel 352; line 1 starts at addr 336.
- Run a full frame → last fetch addr 80639; `VSYNC_b` low for 3 lines from line 245; next frame refetches addr 0 with a second `frame_start`, 456×262×14 cycles after the first.
- Drop `enable` at pixel (100,5) → next cycle all outputs at reset values; re-enable → PRIME, fetch at addr 0.
- Assert `reset` with `enable`=1 mid-line → reset values next cycle; after release, PRIME restarts at (0,0).
